keypad_event_decoder: RTL and testbench
=======================================

Name: keypad_event_decoder

Overview:
- Consumer side of the 4x4 matrix keypad scanner. Takes the raw 16-bit key bitmap and debounces each key.
- Turns debounced press/release transitions into 5-bit key events, serialised lowest key index first.
- Events are buffered in a small FIFO and read through a valid/ready port by the AHB keypad peripheral, or directly by user logic.

Parameters:
- SAMPLE_DIV, 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); legal range >= 2.
- DEBOUNCE_CNT, 20, consecutive differing samples needed to accept a new key level; legal range >= 1.
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active high
- key  input  16  raw scanner bitmap, active low (0 = pressed); bit 4*r+c is row r, column c; asynchronous to debounce, not glitch-free
- key_down  output  16  debounced state, active high (1 = pressed)
- evt_valid  output  1  FIFO non-empty
- evt_data  output  5  head event: bit4 = 1 press / 0 release; bits[3:0] = key index
- evt_ready  input  1  consumer accepts head when evt_valid is also high
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of stored events

Behaviour:
- Reset values (async assert, release synchronous to clk):
  - tick counter = 0
  - all debounce counters = 0
  - stable = 16'hFFFF, reported = 16'hFFFF
  - FIFO empty, so evt_valid = 0 and fifo_count = 0
  - evt_data = 0, key_down = 0
- Sample tick:
  - Counter runs 0..SAMPLE_DIV-1 and wraps.
  - tick = 1 for one clk while the counter equals SAMPLE_DIV-1.
- key is double-flopped before use.
- Per-key debounce, evaluated only on tick:
  - If synced key[i] == stable[i], cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CNT-1, stable[i] <= synced key[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CNT ticks never changes stable.
- key_down = ~stable, driven from registers.
- Serialiser, every clk:
  - Select the lowest i with stable[i] != reported[i].
  - If one exists and the FIFO is not full at the start of the cycle: push {~stable[i], i[3:0]} and set reported[i] <= stable[i].
  - At most one push per clk, so simultaneous changes come out in ascending index order on consecutive clks.
- Latency: stable updates at edge E0; the push happens at E0+1; evt_valid is high after E0+1 if the FIFO was empty.
- Backpressure:
  - When the FIFO is full, no push occurs and reported is held. No event is lost or duplicated.
  - If a key toggles twice while blocked, stable == reported again and nothing is emitted for that pair. This is the defined behaviour.
- FIFO:
  - Pop occurs when evt_valid & evt_ready; evt_data advances to the next entry on the following clk.
  - Push and pop in the same clk: both take effect and the count is unchanged.
  - A push while full is blocked even if a pop happens in the same cycle.
  - Pop while empty: ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all state returns to reset values immediately; keys held across reset produce press events once debounced again.

Decomposition:
- Shared package keypad_pkg holds:
  - KEY_NUM = 16
  - EVT_W = 5
  - EVT_PRESS_BIT = 4
  - event field widths
- Sub-module keypad_evt_fifo: synchronous FIFO with parameters WIDTH and DEPTH, plus push/full and pop/empty/count. Debounce and serialiser logic stay in the top module.

Test Plan (SAMPLE_DIV=4, DEBOUNCE_CNT=3, FIFO_DEPTH=4):
- key[5] driven low and held -> after 3 ticks key_down = 16'h0020; one clk later evt_valid = 1 and evt_data = 5'b1_0101. Release -> evt_data = 5'b0_0101.
- key[9] driven low for 2 ticks only, then high -> key_down stays 0 and evt_valid never asserts.
- key[3], key[0], key[12] driven low in the same cycle, evt_ready = 1 -> events 5'h10, 5'h13, 5'h1C appear on consecutive clks.
- evt_ready = 0 while 6 keys are pressed together -> fifo_count saturates at 4. Then evt_ready = 1 -> exactly 6 press events in ascending index order, none duplicated.
- FIFO at count 2, single push and pop in the same clk -> fifo_count remains 2 and the head advances.
- rst pulsed while the FIFO holds 3 events and key[7] is mid-debounce -> evt_valid = 0, fifo_count = 0, key_down = 0. With key[7] still held low, one press event for 5'h17 follows after 3 ticks.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event decoder.
// Holds key count, event word layout and a helper that packs an event word.
package keypad_pkg;

    localparam int unsigned KEY_NUM       = 16;
    localparam int unsigned KEY_IDX_W     = 4;
    localparam int unsigned EVT_W         = 5;
    localparam int unsigned EVT_PRESS_BIT = 4;

    typedef logic [KEY_IDX_W-1:0] key_idx_t;
    typedef logic [EVT_W-1:0]     evt_t;

    // Event word: {press, key index}; press = 1 for a press, 0 for a release.
    function automatic evt_t make_evt(input logic press, input key_idx_t idx);
        return {press, idx};
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Synchronous FIFO for keypad events.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write request and data; ignored while full
//   full             FIFO holds DEPTH entries
//   pop              read request; ignored while empty
//   pop_data         head entry
//   empty            FIFO holds no entries
//   count            number of stored entries
module keypad_evt_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/keypad_event_decoder.sv
// Keypad event decoder: debounces the raw 4x4 scanner bitmap and emits
// press/release events, lowest key index first, through an event FIFO.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   key          raw bitmap, active low, asynchronous to clk
//   key_down     debounced key state, active high
//   evt_valid    FIFO non-empty
//   evt_data     head event {press, index}
//   evt_ready    consumer accepts the head event
//   fifo_count   number of stored events
module keypad_event_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = 50000,
    parameter int unsigned DEBOUNCE_CNT = 20,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [KEY_NUM-1:0]            key,
    output logic [KEY_NUM-1:0]            key_down,
    output logic                          evt_valid,
    output logic [EVT_W-1:0]              evt_data,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);
    localparam int unsigned CNT_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CNT - 1);

    logic [TICK_W-1:0]  tick_cnt_q;
    logic               tick;
    logic [KEY_NUM-1:0] key_meta_q, key_sync_q;
    logic [CNT_W-1:0]   db_cnt_q [KEY_NUM];
    logic [KEY_NUM-1:0] stable_q, reported_q;
    logic               found, fifo_full, fifo_empty, push;
    key_idx_t           sel_idx;
    evt_t               push_data;

    assign tick = (tick_cnt_q == TICK_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Two-flop synchroniser; resets to "all released" (active low).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
        end else begin
            key_meta_q <= key;
            key_sync_q <= key_meta_q;
        end
    end

    // Per-key debounce: a new level is accepted only after DEBOUNCE_CNT
    // consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(KEY_NUM); i++) begin
                db_cnt_q[i] <= '0;
            end
            stable_q <= '1;
        end else if (tick) begin
            for (int i = 0; i < int'(KEY_NUM); i++) begin
                if (key_sync_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CNT_MAX) begin
                    stable_q[i] <= key_sync_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign key_down = ~stable_q;

    // Downward scan so the lowest differing index is the one left selected.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = int'(KEY_NUM) - 1; i >= 0; i--) begin
            if (stable_q[i] != reported_q[i]) begin
                found   = 1'b1;
                sel_idx = key_idx_t'(i);
            end
        end
    end

    assign push      = found & ~fifo_full;
    assign push_data = make_evt(~stable_q[sel_idx], sel_idx);

    // reported only follows stable when the event actually enters the FIFO,
    // so a blocked change is retried rather than lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reported_q <= '1;
        end else if (push) begin
            reported_q[sel_idx] <= stable_q[sel_idx];
        end
    end

    keypad_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (evt_ready),
        .pop_data  (evt_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign evt_valid = ~fifo_empty;

endmodule

// File: tb/tb_keypad_event_decoder.sv
module tb_keypad_event_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key;
    logic [15:0] key_down;
    logic        evt_valid;
    logic [4:0]  evt_data;
    logic        evt_ready;
    logic [2:0]  fifo_count;

    keypad_event_decoder #(
        .SAMPLE_DIV   (4),
        .DEBOUNCE_CNT (3),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_down   (key_down),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_ready  (evt_ready),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit valid_seen;

    logic [4:0]  exp_q[$];
    int          pop_cyc[$];
    logic [15:0] exp_down;

    typedef struct {
        logic [15:0] key;
        logic [15:0] down;
    } vec_t;

    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every accepted event is matched against the model queue.
    always @(negedge clk) begin
        #1;
        if (evt_valid) valid_seen = 1'b1;
        if (evt_valid && evt_ready && !rst) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got=%0h expected=none", evt_data);
            end else begin
                check("event", {27'd0, evt_data}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    // Drive a new raw bitmap and queue the events the model predicts.
    task automatic apply_keys(input logic [15:0] k);
        logic [15:0] nd;
        logic [4:0]  e;
        nd = ~k;
        for (int i = 0; i < 16; i++) begin
            if (nd[i] != exp_down[i]) begin
                e = {nd[i], i[3:0]};
                exp_q.push_back(e);
            end
        end
        exp_down = nd;
        key      = k;
    endtask

    task automatic wait_level(input int idx, input logic val, input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (key_down[idx] === val) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{key: 16'hFFDF, down: 16'h0020};
        vecs[1] = '{key: 16'hFFFF, down: 16'h0000};
        vecs[2] = '{key: 16'h0000, down: 16'hFFFF};
        vecs[3] = '{key: 16'hFFFF, down: 16'h0000};
        vecs[4] = '{key: 16'h5A5A, down: 16'hA5A5};
        vecs[5] = '{key: 16'hFFFF, down: 16'h0000};

        exp_down  = '0;
        key       = 16'hFFFF;
        evt_ready = 1'b1;
        rst       = 1'b1;
        wait_clks(3);
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_down", {16'd0, key_down}, 32'd0);
        check("rst_data", {27'd0, evt_data}, 32'd0);
        rst = 1'b0;
        wait_clks(2);

        // key5 press/release with exact one-clock push latency
        apply_keys(~16'h0020);
        wait_level(5, 1'b1, "wait_k5_down");
        check("k5_valid_e0", {31'd0, evt_valid}, 32'd0);
        check("k5_down", {16'd0, key_down}, 32'h0020);
        @(negedge clk);
        check("k5_valid_e1", {31'd0, evt_valid}, 32'd1);
        check("k5_press", {27'd0, evt_data}, 32'h15);
        apply_keys(16'hFFFF);
        wait_level(5, 1'b0, "wait_k5_up");
        @(negedge clk);
        check("k5_release", {27'd0, evt_data}, 32'h05);
        wait_clks(10);

        // key9 glitch of exactly two ticks must be filtered
        valid_seen = 1'b0;
        key = ~16'h0200;
        wait_clks(8);
        key = 16'hFFFF;
        wait_clks(40);
        check("glitch_down", {16'd0, key_down}, 32'd0);
        check("glitch_valid", {31'd0, valid_seen}, 32'd0);

        // simultaneous presses serialise on consecutive clocks
        pop_cyc.delete();
        apply_keys(~16'h1009);
        wait_clks(40);
        check("simul_pops", pop_cyc.size(), 32'd3);
        if (pop_cyc.size() == 3) begin
            check("simul_gap0", pop_cyc[1] - pop_cyc[0], 32'd1);
            check("simul_gap1", pop_cyc[2] - pop_cyc[1], 32'd1);
        end
        apply_keys(16'hFFFF);
        wait_clks(40);

        // table-driven bitmap steps
        for (int v = 0; v < 6; v++) begin
            apply_keys(vecs[v].key);
            wait_clks(60);
            check($sformatf("vec%0d_down", v), {16'd0, key_down}, {16'd0, vecs[v].down});
            check($sformatf("vec%0d_drained", v), exp_q.size(), 32'd0);
        end

        // backpressure: six presses into a four-entry FIFO
        evt_ready = 1'b0;
        apply_keys(~16'h8546);
        wait_clks(60);
        check("bp_count", {29'd0, fifo_count}, 32'd4);
        check("bp_down", {16'd0, key_down}, 32'h8546);
        evt_ready = 1'b1;
        wait_clks(40);
        check("bp_drained", exp_q.size(), 32'd0);
        apply_keys(16'hFFFF);
        wait_clks(60);

        // push and pop in the same clock at count 2
        evt_ready = 1'b0;
        apply_keys(~16'h0804);
        wait_clks(60);
        check("pp_count_pre", {29'd0, fifo_count}, 32'd2);
        apply_keys(~16'h2804);
        wait_level(13, 1'b1, "wait_k13_down");
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("pp_count", {29'd0, fifo_count}, 32'd2);
        check("pp_head", {27'd0, evt_data}, 32'h1B);
        evt_ready = 1'b1;
        wait_clks(20);
        check("pp_drained", exp_q.size(), 32'd0);
        apply_keys(16'hFFFF);
        wait_clks(60);

        // reset mid-operation with key7 part-way through debounce
        evt_ready = 1'b0;
        apply_keys(~16'h0111);
        wait_clks(60);
        check("mr_count_pre", {29'd0, fifo_count}, 32'd3);
        key = ~16'h0080;
        wait_clks(6);
        rst = 1'b1;
        @(negedge clk);
        check("mr_valid", {31'd0, evt_valid}, 32'd0);
        check("mr_count", {29'd0, fifo_count}, 32'd0);
        check("mr_down", {16'd0, key_down}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_down = '0;
        apply_keys(~16'h0080);
        evt_ready = 1'b1;
        wait_clks(60);
        check("mr_down_after", {16'd0, key_down}, 32'h0080);
        check("mr_drained", exp_q.size(), 32'd0);
        apply_keys(16'hFFFF);
        wait_clks(60);
        check("final_drained", exp_q.size(), 32'd0);
        check("final_valid", {31'd0, evt_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
